// File: rtl/boot_pkg.sv
// Shared definitions for the UART boot loader: FSM encodings and frame field widths.
package boot_pkg;

   localparam int unsigned MEM_WORDS_DEF = 512;
   localparam int unsigned LEN_W         = 16;
   localparam int unsigned CSUM_W        = 8;

   typedef enum logic [2:0] {
      S_LEN0,
      S_LEN1,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } boot_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchroniser, mid-bit sampling, one-cycle rx_valid / rx_ferr pulses.
module uart_rx_byte
   import boot_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rx,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_ferr
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   rx_state_t        state_q, state_d;
   logic [1:0]       sync_q;
   logic             prev_q;
   logic             rx_s;
   logic             fall;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       sh_q, sh_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;

   assign rx_s     = sync_q[1];
   assign fall     = prev_q & ~rx_s;
   assign rx_byte  = sh_q;
   assign rx_valid = valid_q;
   assign rx_ferr  = ferr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '1;
         prev_q  <= 1'b1;
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], uart_rx};
         prev_q  <= rx_s;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      sh_d    = sh_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (fall) state_d = RX_START;
         end
         RX_START: begin
            // Re-check the line half a bit after the edge; a high level means a glitch.
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               bit_d = '0;
               state_d = rx_s ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               sh_d  = {rx_s, sh_q[7:1]};
               bit_d = bit_q + 1'b1;
               if (bit_q == 3'd7) state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               state_d = RX_IDLE;
               valid_d = rx_s;
               ferr_d  = ~rx_s;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed image from UART into instruction memory,
// holding the core until the image is written and verified.
module uart_boot_loader
   import boot_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned MEM_WORDS    = MEM_WORDS_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        uart_rx,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        load_error,
   output logic [9:0]  words_loaded
);

   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_ferr;

   uart_rx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk      (clk),
      .rst_n    (rst_n),
      .uart_rx  (uart_rx),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid),
      .rx_ferr  (rx_ferr)
   );

   boot_state_t       state_q, state_d;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  len_full;
   logic [1:0]        lane_q;
   logic [CSUM_W-1:0] csum_q;
   logic [23:0]       word_buf;
   logic [9:0]        wl_q;
   logic              we_q;
   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;

   assign len_full     = {rx_byte, len_q[7:0]};
   assign imem_we      = we_q;
   assign imem_addr    = addr_q;
   assign imem_wdata   = wdata_q;
   assign words_loaded = wl_q;
   assign cpu_hold     = (state_q != S_DONE);
   assign load_done    = (state_q == S_DONE);
   assign load_error   = (state_q == S_ERR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_LEN0;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_LEN0: if (rx_valid) state_d = S_LEN1;
         S_LEN1: begin
            if (rx_valid) begin
               if (len_full > LEN_W'(MEM_WORDS)) state_d = S_ERR;
               else if (len_full == '0)          state_d = S_CSUM;
               else                              state_d = S_DATA;
            end
         end
         // Leave during the final write cycle, when the counter is about to reach N.
         S_DATA: if (we_q && (LEN_W'(wl_q) + LEN_W'(1) == len_q)) state_d = S_CSUM;
         S_CSUM: if (rx_valid) state_d = (rx_byte == csum_q) ? S_DONE : S_ERR;
         S_DONE: state_d = S_DONE;
         S_ERR:  state_d = S_ERR;
         default: state_d = S_ERR;
      endcase
      if (rx_ferr && state_q != S_DONE && state_q != S_ERR) state_d = S_ERR;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q    <= '0;
         lane_q   <= '0;
         csum_q   <= '0;
         word_buf <= '0;
         wl_q     <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         we_q <= 1'b0;
         if (we_q) wl_q <= wl_q + 1'b1;
         if (rx_valid) begin
            case (state_q)
               S_LEN0: begin
                  len_q[7:0] <= rx_byte;
                  csum_q     <= csum_q ^ rx_byte;
               end
               S_LEN1: begin
                  len_q[15:8] <= rx_byte;
                  csum_q      <= csum_q ^ rx_byte;
               end
               S_DATA: begin
                  csum_q <= csum_q ^ rx_byte;
                  lane_q <= lane_q + 1'b1;
                  case (lane_q)
                     2'd0: word_buf[7:0]   <= rx_byte;
                     2'd1: word_buf[15:8]  <= rx_byte;
                     2'd2: word_buf[23:16] <= rx_byte;
                     default: begin
                        we_q    <= 1'b1;
                        wdata_q <= {rx_byte, word_buf};
                        addr_q  <= {20'b0, wl_q, 2'b00};
                     end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed, table-driven bench for uart_boot_loader with CLKS_PER_BIT = 8.
module tb_uart_boot_loader;

   localparam int unsigned CPB = 8;

   logic        clk;
   logic        rst_n;
   logic        uart_rx;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        load_done;
   logic        load_error;
   logic [9:0]  words_loaded;

   uart_boot_loader #(
      .CLKS_PER_BIT(CPB),
      .MEM_WORDS   (512)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .uart_rx      (uart_rx),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .cpu_hold     (cpu_hold),
      .load_done    (load_done),
      .load_error   (load_error),
      .words_loaded (words_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];

   always @(negedge clk) begin
      if (imem_we) begin
         wr_addr.push_back(imem_addr);
         wr_data.push_back(imem_wdata);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      uart_rx = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(posedge clk);
      end
      uart_rx = stop;
      repeat (CPB) @(posedge clk);
      uart_rx = 1'b1;
      repeat (2 * CPB) @(posedge clk);
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      uart_rx = 1'b1;
      repeat (3) @(posedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      wr_addr.delete();
      wr_data.delete();
   endtask

   task automatic check_final(input string tag, input logic done, input logic err,
                              input logic [9:0] wl);
      repeat (3 * CPB) @(posedge clk);
      @(negedge clk);
      check({tag, ".load_done"},    32'(load_done),    32'(done));
      check({tag, ".load_error"},   32'(load_error),   32'(err));
      check({tag, ".cpu_hold"},     32'(cpu_hold),     32'(!done));
      check({tag, ".words_loaded"}, 32'(words_loaded), 32'(wl));
   endtask

   typedef struct {
      string       name;
      int unsigned nbytes;
      logic [7:0]  b [16];
      int          ferr_idx;
      logic        exp_done;
      logic        exp_err;
      int unsigned exp_nwr;
      logic [3:0][31:0] exp_words;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0].name = "one_word";
      vecs[0].nbytes = 7;
      vecs[0].b = '{0:8'h01, 1:8'h00, 2:8'h13, 3:8'h05, 4:8'hA0, 5:8'h00, 6:8'hB7,
                    default:8'h00};
      vecs[0].ferr_idx = -1;
      vecs[0].exp_done = 1'b1; vecs[0].exp_err = 1'b0; vecs[0].exp_nwr = 1;
      vecs[0].exp_words = {32'h0, 32'h0, 32'h0, 32'h00A00513};

      vecs[1].name = "three_words";
      vecs[1].nbytes = 15;
      vecs[1].b = '{0:8'h03, 1:8'h00,
                    2:8'h11, 3:8'h11, 4:8'h11, 5:8'h11,
                    6:8'h22, 7:8'h22, 8:8'h22, 9:8'h22,
                    10:8'h33, 11:8'h33, 12:8'h33, 13:8'h33,
                    14:8'h03, default:8'h00};
      vecs[1].ferr_idx = -1;
      vecs[1].exp_done = 1'b1; vecs[1].exp_err = 1'b0; vecs[1].exp_nwr = 3;
      vecs[1].exp_words = {32'h0, 32'h33333333, 32'h22222222, 32'h11111111};

      vecs[2].name = "bad_csum";
      vecs[2].nbytes = 7;
      vecs[2].b = '{0:8'h01, 1:8'h00, 2:8'h13, 3:8'h05, 4:8'hA0, 5:8'h00, 6:8'h00,
                    default:8'h00};
      vecs[2].ferr_idx = -1;
      vecs[2].exp_done = 1'b0; vecs[2].exp_err = 1'b1; vecs[2].exp_nwr = 1;
      vecs[2].exp_words = {32'h0, 32'h0, 32'h0, 32'h00A00513};

      vecs[3].name = "len_overflow";
      vecs[3].nbytes = 7;
      vecs[3].b = '{0:8'h01, 1:8'h02, 2:8'h11, 3:8'h22, 4:8'h33, 5:8'h44, 6:8'h5A,
                    default:8'h00};
      vecs[3].ferr_idx = -1;
      vecs[3].exp_done = 1'b0; vecs[3].exp_err = 1'b1; vecs[3].exp_nwr = 0;
      vecs[3].exp_words = '0;

      vecs[4].name = "framing_err";
      vecs[4].nbytes = 7;
      vecs[4].b = '{0:8'h01, 1:8'h00, 2:8'h13, 3:8'h05, 4:8'hA0, 5:8'h00, 6:8'hB7,
                    default:8'h00};
      vecs[4].ferr_idx = 4;
      vecs[4].exp_done = 1'b0; vecs[4].exp_err = 1'b1; vecs[4].exp_nwr = 0;
      vecs[4].exp_words = '0;

      rst_n   = 1'b0;
      uart_rx = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset.cpu_hold",     32'(cpu_hold),     32'd1);
      check("reset.imem_we",      32'(imem_we),      32'd0);
      check("reset.load_done",    32'(load_done),    32'd0);
      check("reset.load_error",   32'(load_error),   32'd0);
      check("reset.imem_addr",    imem_addr,         32'd0);
      check("reset.imem_wdata",   imem_wdata,        32'd0);
      check("reset.words_loaded", 32'(words_loaded), 32'd0);

      for (int v = 0; v < 5; v++) begin
         do_reset();
         for (int i = 0; i < int'(vecs[v].nbytes); i++)
            send_byte(vecs[v].b[i], (i == vecs[v].ferr_idx) ? 1'b0 : 1'b1);
         check_final(vecs[v].name, vecs[v].exp_done, vecs[v].exp_err,
                     10'(vecs[v].exp_nwr));
         check({vecs[v].name, ".nwrites"}, 32'(wr_addr.size()), 32'(vecs[v].exp_nwr));
         for (int i = 0; i < int'(vecs[v].exp_nwr); i++) begin
            if (i < wr_addr.size()) begin
               check({vecs[v].name, ".addr"}, wr_addr[i], 32'(4 * i));
               check({vecs[v].name, ".data"}, wr_data[i], vecs[v].exp_words[i]);
            end
         end
      end

      // Mid-frame reset after a framing error, then a valid empty image.
      do_reset();
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h13, 1'b1);
      send_byte(8'h05, 1'b1);
      send_byte(8'hA0, 1'b0);
      send_byte(8'h00, 1'b1);
      @(negedge clk);
      check("ferr_then_reset.load_error", 32'(load_error), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("midreset.load_error",   32'(load_error),   32'd0);
      check("midreset.cpu_hold",     32'(cpu_hold),     32'd1);
      check("midreset.words_loaded", 32'(words_loaded), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      wr_addr.delete();
      wr_data.delete();
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      check_final("after_reset_n0", 1'b1, 1'b0, 10'd0);
      check("after_reset_n0.nwrites", 32'(wr_addr.size()), 32'd0);

      // Short low glitch on an idle line must be discarded silently.
      do_reset();
      @(posedge clk);
      uart_rx = 1'b0;
      repeat (3) @(posedge clk);
      uart_rx = 1'b1;
      repeat (3 * CPB) @(posedge clk);
      @(negedge clk);
      check("glitch.load_error", 32'(load_error), 32'd0);
      check("glitch.load_done",  32'(load_done),  32'd0);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      check_final("glitch_n0", 1'b1, 1'b0, 10'd0);

      // Break condition: line held low through the stop bit.
      do_reset();
      uart_rx = 1'b0;
      repeat (12 * CPB) @(posedge clk);
      check_final("break", 1'b0, 1'b1, 10'd0);
      uart_rx = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
